stage_1: RTL and testbench
==========================

Name: stage_1

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC, issues word fetches to instruction memory over a valid/ready request and in-order response interface, and buffers returned instructions in a small fetch queue. It drives the IF/ID pipeline register (if_id_pc, if_id_inst) consumed by stage_2. It redirects on b_taken/b_pc from the stage_2 branch unit.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) loaded into IF/ID on bubble/flush
FQ_DEPTH, 2, fetch-queue entries; also the maximum number of outstanding imem requests

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
b_taken  in  1  redirect request from stage_2 branch unit
b_pc  in  32  redirect target
stall  in  1  hold IF/ID (hazard unit)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, at least 1 cycle after acceptance
imem_rsp_data  in  32  instruction word
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  32  PC of if_id_inst
if_id_inst  out  32  instruction to stage_2
fetch_misaligned  out  1  sticky; redirect target not word-aligned

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=BOOT, fq empty, outstanding=0, drop_cnt=0, if_id_valid=0, if_id_pc=RESET_PC, if_id_inst=NOP_INST, fetch_misaligned=0, imem_req_valid=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after reset release; no requests; then RUN.
  - RUN: normal operation.
  - HALT: entered on b_taken with b_pc[1:0]!=0. Sets fetch_misaligned=1 and flushes as for a redirect. No further requests; IF/ID holds bubble. Leaves only by reset.
- Request issue (RUN only): imem_req_valid = (fq_count + outstanding < FQ_DEPTH); imem_req_addr = pc. On handshake, pc += 4 and outstanding increments. Both counters are registered values.
- Response: imem_rsp_valid is ignored when outstanding==0. Otherwise outstanding decrements. If drop_cnt>0, the response is discarded and drop_cnt decrements; otherwise it is a live response carrying resp_pc. resp_pc comes from a PC-tag FIFO of depth FQ_DEPTH, pushed at issue and popped at response.
- IF/ID update at clock edge, priority highest first:
  1. b_taken: IF/ID becomes a bubble (valid=0, inst=NOP_INST, pc unchanged); fq flushed; pc=b_pc; drop_cnt = outstanding value after this cycle's issue/return, so a request issued in the same cycle is counted and dropped.
  2. stall: IF/ID holds. A live response is pushed into the fq; space is guaranteed by the credit rule.
  3. Otherwise, if fq is non-empty: pop the head into IF/ID with valid=1. A live response in the same cycle is pushed.
  4. Else, if a live response is present: bypass it directly into IF/ID with valid=1.
  5. Else: bubble.
- Latency: request accepted at edge N, response in cycle N+1 with no stall puts the instruction in IF/ID at edge N+2. Sustained throughput is 1 instr/cycle with a 1-cycle memory.
- fq is a circular buffer with wrapping read/write pointers; fq_count is in the range 0..FQ_DEPTH. A push when full is impossible by construction; the bench asserts it never happens.
- Mid-operation reset clears all state, including outstanding and drop_cnt. Late responses from before the reset are ignored because outstanding==0.
- Widths: pc arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.

Decomposition:
- constants.vh gains NOP_INST and the FSM state encodings (BOOT/RUN/HALT).
- One sub-module, fetch_queue: parameterised FIFO storing {pc, inst} with push, pop, flush, count, empty and full.
- The PC-tag FIFO reuses fetch_queue, with the inst field tied off.

Test Plan:
- Reset release, memory always ready, 1-cycle response: IF/ID shows pc 0x0,0x4,0x8… with valid=1 from cycle 3 and no bubbles thereafter.
- stall held 3 cycles mid-stream:
  - IF/ID holds pc 0x8.
  - imem_req_valid drops once fq_count+outstanding==2.
  - After release, 0xC and 0x10 issue on consecutive cycles with none lost or duplicated.
- b_taken with b_pc=0x100 while 2 requests are outstanding:
  - Next IF/ID is a bubble.
  - Both old responses are dropped.
  - The first valid IF/ID pc is 0x100.
- Two back-to-back b_taken (0x200, then 0x300) with a 3-cycle memory: only pc 0x300 and onward reach IF/ID; drop_cnt returns to 0.
- b_taken with b_pc=0x102: fetch_misaligned=1, FSM=HALT, imem_req_valid stays 0, if_id_valid=0 until rst is pulsed low.
- rst asserted while 1 request is outstanding and the response arrives after release: the response is ignored and fetching restarts at RESET_PC after BOOT.

Source files
------------

// File: rtl/stage_1_pkg.sv
// rtl/stage_1_pkg.sv - shared constants and FSM encoding for the instruction-fetch stage
package stage_1_pkg;

    // addi x0,x0,0 : what stage_2 sees whenever IF/ID holds a bubble
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/stage_1_fetch_queue.sv
// rtl/stage_1_fetch_queue.sv - small circular FIFO with flush, used for fetched words and PC tags
module stage_1_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

    // Pointer and occupancy bookkeeping; flush discards everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stage_1.sv
// rtl/stage_1.sv - RV32I instruction-fetch stage: PC, imem requests, fetch queue, IF/ID register
module stage_1
    import stage_1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2,
    localparam int         CW       = $clog2(FQ_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        b_taken,
    input  logic [31:0] b_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        fetch_misaligned
);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] fq_count;
    logic [CW:0]   inflight;
    logic          fq_empty, fq_full, fq_push, fq_pop;
    logic          tag_empty, tag_full;
    logic [63:0]   fq_head;
    logic [31:0]   tag_head;
    logic          req_fire, rsp_fire, rsp_live, redirect, misaligned;
    logic          unused_flags;

    assign req_fire   = imem_req_valid & imem_req_ready;
    // With nothing in flight a response strobe cannot belong to us (e.g. it predates a reset)
    assign rsp_fire   = imem_rsp_valid & (outstanding != '0);
    assign rsp_live   = rsp_fire & (drop_cnt == '0);
    assign redirect   = b_taken & (state_q != HALT);
    assign misaligned = (b_pc[1:0] != 2'b00);
    assign inflight   = {1'b0, fq_count} + {1'b0, outstanding};
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

    assign fq_pop  = !redirect && !stall && !fq_empty;
    assign fq_push = rsp_live && !redirect && (stall || !fq_empty);
    assign imem_req_addr = pc;
    assign unused_flags  = &{1'b0, fq_full, tag_empty, tag_full};

    // PC tags of requests in flight; its occupancy is the outstanding count
    stage_1_fetch_queue #(.DEPTH(FQ_DEPTH), .WIDTH(32)) tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .head_data (tag_head),
        .count     (outstanding),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // Returned instructions waiting for IF/ID while stage_2 stalls
    stage_1_fetch_queue #(.DEPTH(FQ_DEPTH), .WIDTH(64)) fq (
        .clk       (clk),
        .rst       (rst),
        .push      (fq_push),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (fq_pop),
        .flush     (redirect),
        .head_data (fq_head),
        .count     (fq_count),
        .empty     (fq_empty),
        .full      (fq_full)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= BOOT;
        else      state_q <= state_d;
    end

    // Next state and request valid; credits keep queue plus in-flight within FQ_DEPTH
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     imem_req_valid = (inflight < (CW + 1)'(FQ_DEPTH));
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
        if (redirect && misaligned) state_d = HALT;
    end

    // PC, drop counter and sticky misalignment flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc               <= RESET_PC;
            drop_cnt         <= '0;
            fetch_misaligned <= 1'b0;
        end else begin
            if (redirect)      pc <= b_pc;
            else if (req_fire) pc <= pc + 32'd4;
            // Everything still in flight after this edge belongs to the old path
            if (redirect)                         drop_cnt <= outstanding_next;
            else if (rsp_fire && drop_cnt != '0)  drop_cnt <= drop_cnt - 1'b1;
            if (redirect && misaligned) fetch_misaligned <= 1'b1;
        end
    end

    // IF/ID register: redirect, then stall, then queue head, then bypass, else bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= RESET_PC;
            if_id_inst  <= NOP_INST;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else if (!fq_empty) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= fq_head[63:32];
            if_id_inst  <= fq_head[31:0];
        end else if (rsp_live) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= tag_head;
            if_id_inst  <= imem_rsp_data;
        end else begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_stage_1.sv
// tb/tb_stage_1.sv - randomized and directed bench for stage_1 against a queue-based model
module tb_stage_1;

    localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct { logic [31:0] pc; logic stale; } tag_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        b_taken = 1'b0;
    logic [31:0] b_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        fetch_misaligned;

    always #5 clk = ~clk;

    stage_1 dut (
        .clk              (clk),
        .rst              (rst),
        .b_taken          (b_taken),
        .b_pc             (b_pc),
        .stall            (stall),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_inst       (if_id_inst),
        .fetch_misaligned (fetch_misaligned)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          m_st;
    logic [31:0] m_pc;
    tag_t        m_tags[$];
    ent_t        m_fq[$];
    logic        m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_inst;
    logic        m_mis;
    mreq_t       mem_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_st = S_BOOT;
        m_pc = 32'h0;
        m_tags.delete();
        m_fq.delete();
        m_v    = 1'b0;
        m_ipc  = 32'h0;
        m_inst = NOP;
        m_mis  = 1'b0;
    endfunction

    function automatic bit model_req();
        return (m_st == S_RUN) && (m_fq.size() + m_tags.size() < 2);
    endfunction

    task automatic fq_put(input logic [31:0] p, input logic [31:0] d);
        check("model_fq_room", 32'(m_fq.size() < 2), 32'd1);
        m_fq.push_back('{p, d});
    endtask

    // One clock of the reference: responses retire oldest tag, redirects mark everything in flight stale
    task automatic model_update(input bit bt, input logic [31:0] bpc, input bit st,
                                input bit fire, input bit rsp, input logic [31:0] data);
        tag_t t;
        ent_t e;
        bit live = 1'b0;
        logic [31:0] rpc = '0;
        if (rsp && m_tags.size() > 0) begin
            t    = m_tags.pop_front();
            live = !t.stale;
            rpc  = t.pc;
        end
        if (fire) begin
            m_tags.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (bt && m_st != S_HALT) begin
            foreach (m_tags[i]) m_tags[i].stale = 1'b1;
            m_fq.delete();
            m_v    = 1'b0;
            m_inst = NOP;
            m_pc   = bpc;
            if (bpc[1:0] != 2'b00) begin
                m_st  = S_HALT;
                m_mis = 1'b1;
            end
        end else if (st) begin
            if (live) fq_put(rpc, data);
        end else if (m_fq.size() > 0) begin
            e      = m_fq.pop_front();
            m_v    = 1'b1;
            m_ipc  = e.pc;
            m_inst = e.inst;
            if (live) fq_put(rpc, data);
        end else if (live) begin
            m_v    = 1'b1;
            m_ipc  = rpc;
            m_inst = data;
        end else begin
            m_v    = 1'b0;
            m_inst = NOP;
        end
        if (m_st == S_BOOT) m_st = S_RUN;
    endtask

    task automatic compare_all();
        check("if_id_valid", 32'(if_id_valid), 32'(m_v));
        check("if_id_pc", if_id_pc, m_ipc);
        check("if_id_inst", if_id_inst, m_inst);
        check("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
        check("imem_req_valid", 32'(imem_req_valid), 32'(model_req()));
        if (model_req()) check("imem_req_addr", imem_req_addr, m_pc);
    endtask

    // Drive one cycle of inputs at the falling edge, advance model and memory, compare after the rising edge
    task automatic step(input bit r, input bit bt, input logic [31:0] bpc,
                        input bit st, input bit rdy, input int lat);
        bit rv, fire, rsp;
        rv  = r && model_req();
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rst            = r;
        b_taken        = bt;
        b_pc           = bpc;
        stall          = st;
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        fire = rv && rdy;
        if (rsp) void'(mem_q.pop_front());
        if (fire) mem_q.push_back('{m_pc, cyc + lat});
        if (!r) model_reset();
        else    model_update(bt, bpc, st, fire, rsp, imem_rsp_data);
        #1;
        check("fq_push_when_full", 32'(dut.fq_push && dut.fq_full), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n, input int lat);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, lat);
    endtask

    task automatic run_until_valid(input int lat, input logic [31:0] exp_pc, input string name);
        for (int i = 0; i < 16 && !if_id_valid; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, lat);
        check({name, "_reached"}, 32'(if_id_valid), 32'd1);
        check({name, "_pc"}, if_id_pc, exp_pc);
    endtask

    initial begin
        bit r, bt, st, rdy;
        logic [31:0] bpc;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("reset_inst", if_id_inst, 32'h0000_0013);
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);

        // Straight-line fetch with a 1-cycle memory
        run(3, 1);
        check("first_valid", 32'(if_id_valid), 32'd1);
        check("first_pc", if_id_pc, 32'h0);
        run(2, 1);
        check("third_pc", if_id_pc, 32'h8);

        // Stall three cycles mid-stream
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            check("stall_hold_pc", if_id_pc, 32'h8);
        end
        run(1, 1);
        check("after_stall_pc0", if_id_pc, 32'hC);
        run(1, 1);
        check("after_stall_pc1", if_id_pc, 32'h10);
        run(4, 1);

        // Redirect with requests in flight on a slow memory
        run(4, 3);
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 3);
        check("redirect_bubble", 32'(if_id_valid), 32'd0);
        run_until_valid(3, 32'h100, "redirect_100");
        run(3, 3);

        // Back-to-back redirects
        step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 3);
        step(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 3);
        run_until_valid(3, 32'h300, "redirect_300");
        run(6, 3);
        check("drop_cnt_drained", 32'(dut.drop_cnt), 32'd0);

        // Misaligned redirect halts until reset
        step(1'b1, 1'b1, 32'h102, 1'b0, 1'b1, 1);
        check("misaligned_flag", 32'(fetch_misaligned), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
            check("halt_no_req", 32'(imem_req_valid), 32'd0);
            check("halt_bubble", 32'(if_id_valid), 32'd0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("halt_cleared", 32'(fetch_misaligned), 32'd0);

        // Reset with a request outstanding; its late response must be ignored
        run(3, 3);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
        run_until_valid(1, 32'h0, "restart");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom % 400) != 0;
            if (m_st == S_HALT && ($urandom % 6) == 0) r = 1'b0;
            bt  = ($urandom % 12) == 0;
            bpc = $urandom;
            if (($urandom % 20) != 0) bpc[1:0] = 2'b00;
            if (($urandom % 50) == 0) bpc = 32'hFFFF_FFF8;
            st  = ($urandom % 4) == 0;
            rdy = ($urandom % 4) != 0;
            step(r, bt, bpc, st, rdy, int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
